// File: rtl/rtc_bus_engine.sv
// Burst master for the RTC multiplexed address/data bus (CS/AD/WR/RD, active-low).
// Every output is registered from the next-state decode, so strobes cannot glitch.
module rtc_bus_engine #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 9,
    parameter int T_PHASE   = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [DATA_W-1:0] addr_base,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] wdata,
    output logic              wdata_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [CNT_W-1:0]  rdata_idx,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              CS,
    output logic              AD,
    output logic              WR,
    output logic              RD,
    output logic [2:0]        state_dbg
);
    // Handshakes: start is taken only while busy=0 (ignored otherwise); wdata must be
    // valid in the cycle wdata_ack=1 and is consumed at the end of that cycle.
    localparam int PH_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;

    typedef enum logic [2:0] {IDLE, A_SET, A_HOLD, GAP, DATA, RECOV, FIN} state_t;

    state_t            state, state_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [CNT_W-1:0]  idx, idx_d, cnt_q, cnt_clamped, idx_inc;
    logic              rw_q, rw_d, phase_last, wdata_take;
    logic [DATA_W-1:0] base_q, base_d, wdata_q, wdata_d, addr_d;
    logic              cs_d, ad_d, wr_d, rd_d, oe_d, ack_d, busy_d, done_d;
    logic [DATA_W-1:0] bus_out_d;

    assign phase_last  = (phase == PH_W'(T_PHASE - 1));
    assign cnt_clamped = (count > CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : count;
    assign idx_inc     = idx + 1'b1;
    assign wdata_take  = (state == GAP) && (phase == '0) && !rw_q;
    assign state_dbg   = state;

    always_comb begin
        state_d = state;
        phase_d = phase;
        idx_d   = idx;
        case (state)
            IDLE: begin
                phase_d = '0;
                idx_d   = '0;
                if (start) state_d = (cnt_clamped == '0) ? FIN : A_SET;
            end
            FIN: state_d = IDLE;
            default: begin
                if (phase_last) begin
                    phase_d = '0;
                    case (state)
                        A_SET:  state_d = A_HOLD;
                        A_HOLD: state_d = GAP;
                        GAP:    state_d = DATA;
                        DATA:   state_d = RECOV;
                        RECOV: begin
                            idx_d   = idx_inc;
                            state_d = (idx_inc == cnt_q) ? FIN : A_SET;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    phase_d = phase + 1'b1;
                end
            end
        endcase
    end

    // Output decode looks at the upcoming state so the registers line up with it.
    always_comb begin
        rw_d      = (state == IDLE) ? rw : rw_q;
        base_d    = (state == IDLE) ? addr_base : base_q;
        wdata_d   = wdata_take ? wdata : wdata_q;
        addr_d    = base_d + DATA_W'(idx_d);
        cs_d      = !(state_d inside {A_SET, A_HOLD, GAP, DATA});
        ad_d      = (state_d != A_SET);
        wr_d      = !((state_d == DATA) && !rw_d);
        rd_d      = !((state_d == DATA) && rw_d);
        oe_d      = (state_d inside {A_SET, A_HOLD}) || ((state_d == DATA) && !rw_d);
        bus_out_d = '0;
        if (state_d inside {A_SET, A_HOLD}) bus_out_d = addr_d;
        else if ((state_d == DATA) && !rw_d) bus_out_d = wdata_d;
        ack_d     = (state_d == GAP) && (phase_d == '0) && !rw_d;
        busy_d    = state_d inside {A_SET, A_HOLD, GAP, DATA, RECOV};
        done_d    = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= '0;
            idx         <= '0;
            cnt_q       <= '0;
            rw_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            CS          <= 1'b1;
            AD          <= 1'b1;
            WR          <= 1'b1;
            RD          <= 1'b1;
            bus_oe      <= 1'b0;
            bus_out     <= '0;
            wdata_ack   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_idx   <= '0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            idx       <= idx_d;
            rw_q      <= rw_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            if (state == IDLE && start) cnt_q <= cnt_clamped;
            CS        <= cs_d;
            AD        <= ad_d;
            WR        <= wr_d;
            RD        <= rd_d;
            bus_oe    <= oe_d;
            bus_out   <= bus_out_d;
            wdata_ack <= ack_d;
            busy      <= busy_d;
            done      <= done_d;
            // Read data is captured at the end of the last DATA cycle.
            rdata_valid <= (state == DATA) && phase_last && rw_q;
            if ((state == DATA) && phase_last && rw_q) begin
                rdata     <= bus_in;
                rdata_idx <= idx;
            end
        end
    end
endmodule
